// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Arbiter sequencing state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_P = 2'd1,
        BUSY_L = 2'd2
    } arb_state_t;

    // Which requester currently drives the memory
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_L    = 2'd2
    } owner_t;

    // Addressing-control (funct3) encodings understood by data_mem
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Counter load value on leaving IDLE; unused when an access is a single cycle
    function automatic int unsigned cnt_start(input int unsigned access_cycles);
        return (access_cycles > 1) ? access_cycles - 2 : 0;
    endfunction

endpackage

// File: rtl/arb_fairness_ctr.sv
// Counts consecutive P grants while L waits and forces an L grant at the limit.
module arb_fairness_ctr #(
    parameter int unsigned MAX_P_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic l_req,
    input  logic p_grant,
    input  logic l_grant,
    output logic force_l
);

    localparam int unsigned BW = $clog2(MAX_P_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_P_BURST);

    logic [BW-1:0] burst_cnt;

    // Saturating burst count; only meaningful while L is actually waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (l_grant || !l_req) begin
            burst_cnt <= '0;
        end else if (p_grant && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    assign force_l = (burst_cnt == BURST_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (P) and a loader port (L).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned MAX_P_BURST   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_req,
    input  logic [DATA_WIDTH-1:0] p_addr,
    input  logic [DATA_WIDTH-1:0] p_wd,
    input  logic                  p_we,
    input  logic [2:0]            p_ctrl,
    output logic [DATA_WIDTH-1:0] p_rdata,
    output logic                  p_stall,
    input  logic                  l_req,
    input  logic [DATA_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wd,
    input  logic                  l_we,
    input  logic [2:0]            l_ctrl,
    output logic                  l_ready,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_start(ACCESS_CYCLES));
    localparam bit SINGLE_CYCLE = (ACCESS_CYCLES == 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    owner_t           owner;
    logic             final_cyc;
    logic             force_l;
    logic             p_grant;
    logic             l_grant;

    arb_fairness_ctr #(
        .MAX_P_BURST(MAX_P_BURST)
    ) u_fair (
        .clk    (clk),
        .rst    (rst),
        .l_req  (l_req),
        .p_grant(p_grant),
        .l_grant(l_grant),
        .force_l(force_l)
    );

    // Same-cycle arbitration in IDLE; the busy states keep their owner until done
    always_comb begin
        owner   = OWN_NONE;
        p_grant = 1'b0;
        l_grant = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (l_req && (!p_req || force_l)) begin
                        owner   = OWN_L;
                        l_grant = 1'b1;
                    end else if (p_req) begin
                        owner   = OWN_P;
                        p_grant = 1'b1;
                    end
                end
                BUSY_P:  owner = OWN_P;
                BUSY_L:  owner = OWN_L;
                default: owner = OWN_NONE;
            endcase
        end
    end

    // The last cycle of an access: the grant cycle itself for single-cycle accesses
    always_comb begin
        final_cyc = 1'b0;
        if (owner != OWN_NONE) begin
            final_cyc = (state == IDLE) ? SINGLE_CYCLE : (cnt == '0);
        end
    end

    // Access sequencer: counts the remaining cycles of a multi-cycle access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((p_grant || l_grant) && !SINGLE_CYCLE) begin
                        state <= p_grant ? BUSY_P : BUSY_L;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY_P, BUSY_L: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Memory-side mux and requester handshakes; the write strobe fires once, at the end
    always_comb begin
        mem_a    = '0;
        mem_wd   = '0;
        mem_ctrl = '0;
        mem_we   = 1'b0;
        p_rdata  = '0;
        l_rdata  = '0;
        p_stall  = 1'b0;
        l_ready  = 1'b0;
        unique case (owner)
            OWN_P: begin
                mem_a    = p_addr;
                mem_wd   = p_wd;
                mem_ctrl = p_ctrl;
                mem_we   = p_we && final_cyc;
            end
            OWN_L: begin
                mem_a    = l_addr;
                mem_wd   = l_wd;
                mem_ctrl = l_ctrl;
                mem_we   = l_we && final_cyc;
            end
            default: ;
        endcase
        if (!rst) begin
            p_stall = p_req && !((owner == OWN_P) && final_cyc);
        end
        if ((owner == OWN_P) && final_cyc) begin
            p_rdata = mem_rd;
        end
        if ((owner == OWN_L) && final_cyc) begin
            l_ready = 1'b1;
            l_rdata = mem_rd;
        end
    end

endmodule
